// File: rtl/alu_unit.sv
`default_nettype none
// alu_unit: registered N-bit ALU (add/sub/logic/shifts) with carry/borrow and zero flags, one-cycle latency.
// Optional signed-overflow flag and OVERFLOW port enabled by defining ALU_OVF_EN.

package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6
  } alu_op_t;
endpackage

module alu_unit #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   OP,
  input  logic         IN_VALID,
  output logic [N-1:0] RESULT,
  output logic         CARRY,
  output logic         ZERO,
  output logic         OUT_VALID
`ifdef ALU_OVF_EN
  ,
  output logic         OVERFLOW
`endif
);

  logic [N-1:0] next_result;
  logic         next_carry;

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    case (OP)
      alu_pkg::ALU_ADD: {next_carry, next_result} = {1'b0, A} + {1'b0, B};
      // The N+1-bit difference sets the top bit exactly when A < B (borrow).
      alu_pkg::ALU_SUB: {next_carry, next_result} = {1'b0, A} - {1'b0, B};
      alu_pkg::ALU_AND: next_result = A & B;
      alu_pkg::ALU_OR:  next_result = A | B;
      alu_pkg::ALU_XOR: next_result = A ^ B;
      alu_pkg::ALU_SHL: next_result = A << B;
      alu_pkg::ALU_SHR: next_result = A >> B;
      default: begin
        next_result = '0;
        next_carry  = 1'b0;
      end
    endcase
  end

`ifdef ALU_OVF_EN
  logic next_ovf;

  always_comb begin
    next_ovf = 1'b0;
    case (OP)
      alu_pkg::ALU_ADD: next_ovf = (A[N-1] == B[N-1]) && (next_result[N-1] != A[N-1]);
      alu_pkg::ALU_SUB: next_ovf = (A[N-1] != B[N-1]) && (next_result[N-1] != A[N-1]);
      default:          next_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OVERFLOW <= 1'b0;
    end else if (IN_VALID) begin
      OVERFLOW <= next_ovf;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RESULT    <= '0;
      CARRY     <= 1'b0;
      ZERO      <= 1'b1;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= IN_VALID;
      if (IN_VALID) begin
        RESULT <= next_result;
        CARRY  <= next_carry;
        ZERO   <= (next_result == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// tb_alu_unit: directed and random scoreboard bench for alu_unit at N=16.

module tb_alu_unit;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   OP;
  logic         IN_VALID;
  logic [N-1:0] RESULT;
  logic         CARRY;
  logic         ZERO;
  logic         OUT_VALID;
`ifdef ALU_OVF_EN
  logic         OVERFLOW;
`endif

  alu_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .IN_VALID  (IN_VALID),
    .RESULT    (RESULT),
    .CARRY     (CARRY),
    .ZERO      (ZERO),
    .OUT_VALID (OUT_VALID)
`ifdef ALU_OVF_EN
    ,
    .OVERFLOW  (OVERFLOW)
`endif
  );

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   pass_cnt;
  int   total_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input logic exp_valid, input exp_t e);
    check({tag, ".out_valid"}, {31'b0, OUT_VALID}, {31'b0, exp_valid});
    check({tag, ".result"}, {16'b0, RESULT}, {16'b0, e.r});
    check({tag, ".carry"}, {31'b0, CARRY}, {31'b0, e.c});
    check({tag, ".zero"}, {31'b0, ZERO}, {31'b0, e.z});
`ifdef ALU_OVF_EN
    check({tag, ".overflow"}, {31'b0, OVERFLOW}, {31'b0, e.o});
`endif
  endtask

  // Independent reference: integer arithmetic and explicit range tests.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   s;
    int   sa;
    int   sb_v;
    e  = '0;
    sa = int'($signed(a));
    sb_v = int'($signed(b));
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        e.r = s[15:0];
        e.c = (s > 65535);
        e.o = ((sa + sb_v) > 32767) || ((sa + sb_v) < -32768);
      end
      3'd1: begin
        s = int'(a) - int'(b);
        e.r = s[15:0];
        e.c = (a < b);
        e.o = ((sa - sb_v) > 32767) || ((sa - sb_v) < -32768);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = (b >= 16) ? 16'h0 : (a << b[3:0]);
      3'd6: e.r = (b >= 16) ? 16'h0 : (a >> b[3:0]);
      default: e.r = 16'h0;
    endcase
    e.z = (e.r == 16'h0);
    return e;
  endfunction

  task automatic step(input string tag, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic v,
                      input logic [15:0] er, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    OP = op;
    IN_VALID = v;
    if (v) begin
      e.r = er;
      e.c = ec;
      e.z = (er == 16'h0);
      e.o = eo;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) last_exp = sb.pop_front();
    check_outputs(tag, v, last_exp);
  endtask

  task automatic rand_step(input int idx);
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
    op = 3'($urandom_range(0, 7));
    a  = 16'($urandom);
    b  = (op >= 3'd5) ? 16'($urandom_range(0, 20)) : 16'($urandom);
    e  = model(op, a, b);
    step($sformatf("rand%0d", idx), op, a, b, 1'b1, e.r, e.c, e.o);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    last_exp  = '{r: 16'h0, c: 1'b0, z: 1'b1, o: 1'b0};
    rst = 1'b1;
    A = '0;
    B = '0;
    OP = 3'd0;
    IN_VALID = 1'b0;
    #2;
    check_outputs("reset", 1'b0, last_exp);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);
    step("sub_borrow", 3'd1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    step("sub_equal", 3'd1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0);
    step("and",       3'd2, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, 1'b0);
    step("or",        3'd3, 16'hF0F0, 16'h0FF0, 1'b1, 16'hFFF0, 1'b0, 1'b0);
    step("xor",       3'd4, 16'hF0F0, 16'h0FF0, 1'b1, 16'hFF00, 1'b0, 1'b0);
    step("shl1",      3'd5, 16'h8001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0);
    step("shr15",     3'd6, 16'h8001, 16'h000F, 1'b1, 16'h0001, 1'b0, 1'b0);
    step("shl16",     3'd5, 16'h8001, 16'h0010, 1'b1, 16'h0000, 1'b0, 1'b0);
    step("op7",       3'd7, 16'h8001, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0);
    step("add_plain", 3'd0, 16'h0100, 16'h0023, 1'b1, 16'h0123, 1'b0, 1'b0);
    step("hold",      3'd1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    step("add_ovf",   3'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1);
    step("sub_ovf",   3'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    step("shr0",      3'd6, 16'h8001, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b0);
    step("shr_big",   3'd6, 16'h8001, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) rand_step(i);

    step("pre_reset", 3'd0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0);
    // Reset arrives while a new operation is presented; it must win immediately.
    @(negedge clk);
    A = 16'h0005;
    B = 16'h0005;
    OP = 3'd0;
    IN_VALID = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    last_exp = '{r: 16'h0, c: 1'b0, z: 1'b1, o: 1'b0};
    sb.delete();
    check_outputs("async_rst", 1'b0, last_exp);
    @(posedge clk);
    #1;
    check_outputs("rst_held", 1'b0, last_exp);
    @(negedge clk);
    rst = 1'b0;
    IN_VALID = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1'b0, last_exp);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
